panda_fetch_buffer: RTL and testbench

Parametrised instruction-fetch front end for the Panda pipeline. Replaces the single-register fetch path with a request/grant/response instruction-memory interface, an in-order prefetch FIFO of configurable depth and a valid/ready handoff to decode. Branch and jump redirects flush buffered and in-flight fetches. Sits between instruction memory and the ID stage, feeding the IF/ID boundary.

---
 rtl/panda_fetch_buffer.sv | 188 ++++++++++++++++++
 tb/tb_panda_fetch_buffer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panda_fetch_buffer.sv
// Instruction-fetch front end: request/grant/response fetch, in-order prefetch FIFO,
// redirect flush with discard tracking. Optional macro PANDA_FETCH_BYPASS_EN adds an empty-FIFO bypass.
module panda_fetch_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LP_DEPTH = DEPTH[CW:0];

  logic          r_run;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [31:0]   r_stale_addr;
  logic          r_stale;
  logic [CW-1:0] r_out_cnt;
  logic [CW-1:0] r_disc_cnt;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_mem_instr [DEPTH];
  logic [31:0]   r_mem_pc    [DEPTH];

  logic [CW:0]   w_sum;
  logic          w_req;
  logic [31:0]   w_addr;
  logic [31:0]   w_target;
  logic          w_gnt_fire;
  logic          w_rv_keep;
  logic          w_rv_drop;
  logic          w_fifo_empty;
  logic          w_bypass;
  logic          w_valid;
  logic          w_hs;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_gnt_inc;
  logic [CW-1:0] w_rv_dec;
  logic [CW-1:0] w_push_inc;
  logic [CW-1:0] w_pop_dec;

  // Outstanding + buffered + to-be-discarded words never exceed DEPTH, so a
  // granted fetch always has a FIFO slot waiting for it.
  assign w_sum    = {1'b0, r_out_cnt} + {1'b0, r_count} + {1'b0, r_disc_cnt};
  assign w_req    = r_run & (r_stale | (w_sum < LP_DEPTH));
  assign w_addr   = r_stale ? r_stale_addr : r_fetch_pc;
  assign w_target = redirect_target_i & 32'hFFFF_FFFC;

  assign instr_req_o  = w_req;
  assign instr_addr_o = w_addr;

  assign w_gnt_fire   = w_req & instr_gnt_i;
  assign w_rv_drop    = instr_rvalid_i & (r_disc_cnt != '0);
  assign w_rv_keep    = instr_rvalid_i & (r_disc_cnt == '0);
  assign w_fifo_empty = (r_count == '0);

`ifdef PANDA_FETCH_BYPASS_EN
  assign w_bypass = w_fifo_empty & w_rv_keep & ~redirect_i;
  assign w_push   = w_rv_keep & ~redirect_i & ~(w_bypass & if_ready_i);
`else
  assign w_bypass = 1'b0;
  assign w_push   = w_rv_keep & ~redirect_i;
`endif

  // Decode handshake: a word transfers in any cycle with if_valid_o & if_ready_i;
  // if_valid_o never waits on if_ready_i, and a redirect does not cancel it.
  assign w_valid = ~w_fifo_empty | w_bypass;
  assign w_hs    = w_valid & if_ready_i;
  assign w_pop   = w_hs & ~w_fifo_empty;

  assign w_gnt_inc  = {{(CW-1){1'b0}}, w_gnt_fire};
  assign w_rv_dec   = {{(CW-1){1'b0}}, instr_rvalid_i};
  assign w_push_inc = {{(CW-1){1'b0}}, w_push};
  assign w_pop_dec  = {{(CW-1){1'b0}}, w_pop};

  assign if_valid_o = w_valid;

`ifdef PANDA_FETCH_BYPASS_EN
  always_comb begin
    if_instr_o = '0;
    if_pc_o    = '0;
    if (w_bypass) begin
      if_instr_o = instr_rdata_i;
      if_pc_o    = r_resp_pc;
    end else if (!w_fifo_empty) begin
      if_instr_o = r_mem_instr[r_rd_ptr];
      if_pc_o    = r_mem_pc[r_rd_ptr];
    end
  end
`else
  always_comb begin
    if_instr_o = '0;
    if_pc_o    = '0;
    if (!w_fifo_empty) begin
      if_instr_o = r_mem_instr[r_rd_ptr];
      if_pc_o    = r_mem_pc[r_rd_ptr];
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_run        <= 1'b0;
      r_fetch_pc   <= BOOT_ADDR;
      r_resp_pc    <= BOOT_ADDR;
      r_stale_addr <= '0;
      r_stale      <= 1'b0;
      r_out_cnt    <= '0;
      r_disc_cnt   <= '0;
    end else begin
      r_run <= 1'b1;
      if (redirect_i) begin
        // Everything granted so far, including a grant in this very cycle,
        // belongs to the old path and must be dropped when it returns.
        r_disc_cnt <= r_disc_cnt + r_out_cnt + w_gnt_inc - w_rv_dec;
        r_out_cnt  <= '0;
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_stale    <= w_req & ~instr_gnt_i;
        r_stale_addr <= w_addr;
      end else begin
        if (w_gnt_fire && r_stale) begin
          r_stale    <= 1'b0;
          r_disc_cnt <= r_disc_cnt + 1'b1 - {{(CW-1){1'b0}}, w_rv_drop};
        end else begin
          r_disc_cnt <= r_disc_cnt - {{(CW-1){1'b0}}, w_rv_drop};
        end
        if (w_gnt_fire && !r_stale) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
          r_out_cnt  <= r_out_cnt + 1'b1 - {{(CW-1){1'b0}}, w_rv_keep};
        end else begin
          r_out_cnt  <= r_out_cnt - {{(CW-1){1'b0}}, w_rv_keep};
        end
        if (w_rv_keep) begin
          r_resp_pc <= r_resp_pc + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (redirect_i) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_count <= r_count + w_push_inc - w_pop_dec;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_pc[i]    <= '0;
      end
    end else if (w_push) begin
      r_mem_instr[r_wr_ptr] <= instr_rdata_i;
      r_mem_pc[r_wr_ptr]    <= r_resp_pc;
    end
  end

endmodule

// File: tb/tb_panda_fetch_buffer.sv
// Bench for panda_fetch_buffer: bench-side memory, queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_panda_fetch_buffer;

  localparam int          DEPTH     = 2;
  localparam logic [31:0] BOOT_ADDR = 32'h0000_0100;

  logic        clk;
  logic        rst_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;

  panda_fetch_buffer #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT_ADDR)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .instr_req_o       (instr_req_o),
    .instr_addr_o      (instr_addr_o),
    .instr_gnt_i       (instr_gnt_i),
    .instr_rvalid_i    (instr_rvalid_i),
    .instr_rdata_i     (instr_rdata_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .if_valid_o        (if_valid_o),
    .if_ready_i        (if_ready_i),
    .if_instr_o        (if_instr_o),
    .if_pc_o           (if_pc_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  bit mem_stall = 1'b0;

  // memory and logs
  logic [31:0] mem_q[$];
  logic [31:0] grant_log[$];
  logic [31:0] hs_log[$];
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_hs;
  logic [31:0] s_pc;

  // reference model: exp_q holds {instr, pc} words decode will see; infl_q holds
  // granted fetches as {drop, addr}
  logic [63:0] exp_q[$];
  logic [32:0] infl_q[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_stale_addr;
  logic        m_stale;
  logic        m_run;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_req();
    return m_run && (m_stale || (infl_q.size() + exp_q.size() < DEPTH));
  endfunction

  function automatic logic [31:0] m_addr();
    return m_stale ? m_stale_addr : m_fetch_pc;
  endfunction

  function automatic logic m_byp();
`ifdef PANDA_FETCH_BYPASS_EN
    logic [32:0] h;
    if (exp_q.size() != 0 || !instr_rvalid_i || redirect_i || infl_q.size() == 0) return 1'b0;
    h = infl_q[0];
    return !h[32];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_valid();
    return (exp_q.size() > 0) || m_byp();
  endfunction

  function automatic logic [31:0] m_pc();
    logic [63:0] e;
    logic [32:0] h;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      return e[31:0];
    end
    if (infl_q.size() > 0) begin
      h = infl_q[0];
      return h[31:0];
    end
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_instr();
    logic [63:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      return e[63:32];
    end
    return instr_rdata_i;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    infl_q.delete();
    m_fetch_pc   = BOOT_ADDR;
    m_stale_addr = 32'h0;
    m_stale      = 1'b0;
    m_run        = 1'b0;
  endtask

  task automatic model_step();
    logic        req;
    logic        fire;
    logic        byp;
    logic        hs;
    logic [31:0] addr;
    logic [32:0] e;
    logic [63:0] d;
    req  = m_req();
    fire = req && instr_gnt_i;
    byp  = m_byp();
    hs   = m_valid() && if_ready_i;
    addr = m_addr();
    if (hs && !byp) d = exp_q.pop_front();
    if (instr_rvalid_i) begin
      chk("rvalid_in_flight", 32'(infl_q.size() > 0), 32'd1);
      if (infl_q.size() > 0) begin
        e = infl_q.pop_front();
        if (!e[32] && !redirect_i && !(byp && hs)) exp_q.push_back({instr_rdata_i, e[31:0]});
      end
    end
    if (fire) begin
      if (m_stale) begin
        infl_q.push_back({1'b1, addr});
        m_stale = 1'b0;
      end else begin
        infl_q.push_back({1'b0, m_fetch_pc});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    if (redirect_i) begin
      exp_q.delete();
      foreach (infl_q[i]) infl_q[i] = infl_q[i] | 33'h1_0000_0000;
      m_fetch_pc = redirect_target_i & 32'hFFFF_FFFC;
      if (req && !instr_gnt_i) begin
        m_stale      = 1'b1;
        m_stale_addr = addr;
      end
    end
    m_run = 1'b1;
  endtask

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req", 32'(instr_req_o), 32'(m_req()));
      chk("addr", instr_addr_o, m_addr());
      chk("valid", 32'(if_valid_o), 32'(m_valid()));
      if (m_valid()) begin
        chk("pc", if_pc_o, m_pc());
        chk("instr", if_instr_o, m_instr());
      end
    end
  end

  // driver: one clock cycle of memory + model activity
  task automatic tick();
    logic [31:0] tmp;
    @(negedge clk);
    s_req  = instr_req_o;
    s_addr = instr_addr_o;
    s_hs   = if_valid_o && if_ready_i;
    s_pc   = if_pc_o;
    @(posedge clk);
    if (!rst_i) begin
      model_step();
      if (instr_rvalid_i && mem_q.size() > 0) tmp = mem_q.pop_front();
      if (s_req && instr_gnt_i) begin
        mem_q.push_back(s_addr);
        grant_log.push_back(s_addr);
      end
      if (s_hs) hs_log.push_back(s_pc);
    end
    #1;
    redirect_i = 1'b0;
    if (!rst_i && !mem_stall && mem_q.size() > 0) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = mem_word(mem_q[0]);
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'h0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic redirect_to(input logic [31:0] t);
    redirect_i        = 1'b1;
    redirect_target_i = t;
    tick();
  endtask

  initial begin
    int          n_hs;
    int          gl_mark;
    int          bad;
    int          idx;
    bit          found;
    logic [31:0] v;

    rst_i             = 1'b1;
    instr_gnt_i       = 1'b1;
    instr_rvalid_i    = 1'b0;
    instr_rdata_i     = 32'h0;
    redirect_i        = 1'b0;
    redirect_target_i = 32'h0;
    if_ready_i        = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_req", 32'(instr_req_o), 32'd0);
    chk("rst_addr", instr_addr_o, 32'h0000_0100);
    chk("rst_valid", 32'(if_valid_o), 32'd0);
    chk("rst_instr", if_instr_o, 32'h0);
    chk("rst_pc", if_pc_o, 32'h0);
    rst_i = 1'b0;

    // streaming from BOOT_ADDR
    tick();
    chk("first_req", 32'(instr_req_o), 32'd1);
    chk("first_addr", instr_addr_o, 32'h0000_0100);
    ticks(20);
    chk("hs_count", 32'(hs_log.size() >= 3), 32'd1);
    if (hs_log.size() >= 3) begin
      chk("hs0_pc", hs_log[0], 32'h0000_0100);
      chk("hs1_pc", hs_log[1], 32'h0000_0104);
      chk("hs2_pc", hs_log[2], 32'h0000_0108);
    end

    // decode stalled: FIFO fills, requests stop, nothing lost afterwards
    if_ready_i = 1'b0;
    ticks(8);
    chk("full_req_low", 32'(instr_req_o), 32'd0);
    chk("full_valid", 32'(if_valid_o), 32'd1);
    if_ready_i = 1'b1;
    ticks(10);
    bad = 0;
    foreach (hs_log[i]) if (hs_log[i] != BOOT_ADDR + 32'(4 * i)) bad++;
    chk("hs_sequence_gaps", 32'(bad), 32'd0);

    // two outstanding fetches flushed by a redirect
    mem_stall = 1'b1;
    ticks(6);
    chk("o2_req_low", 32'(instr_req_o), 32'd0);
    chk("o2_outstanding", 32'(mem_q.size()), 32'd2);
    n_hs = hs_log.size();
    mem_stall = 1'b0;
    redirect_to(32'h0000_2002);
    chk("rd_valid_low", 32'(if_valid_o), 32'd0);
    ticks(12);
    chk("rd_hs_seen", 32'(hs_log.size() > n_hs), 32'd1);
    if (hs_log.size() > n_hs) chk("rd_first_pc", hs_log[n_hs], 32'h0000_2000);

    // stale requests held until granted
    instr_gnt_i = 1'b0;
    ticks(4);
    redirect_to(32'h0000_0040);
    ticks(2);
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i = 1'b0;
    tick();
    chk("pend40_req", 32'(instr_req_o), 32'd1);
    chk("pend40_addr", instr_addr_o, 32'h0000_0040);
    gl_mark = grant_log.size();
    n_hs = hs_log.size();
    redirect_to(32'h0000_3001);
    ticks(3);
    chk("held40_addr", instr_addr_o, 32'h0000_0040);
    instr_gnt_i = 1'b1;
    ticks(8);
    chk("stale_grants", 32'(grant_log.size() >= gl_mark + 2), 32'd1);
    if (grant_log.size() >= gl_mark + 2) begin
      chk("stale_g0", grant_log[gl_mark], 32'h0000_0040);
      chk("stale_g1", grant_log[gl_mark + 1], 32'h0000_3000);
    end
    bad = 0;
    for (int i = n_hs; i < hs_log.size(); i++) if (hs_log[i] == 32'h0000_0040) bad++;
    chk("stale_40_dropped", 32'(bad), 32'd0);

    // redirect coinciding with a decode handshake and a response
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (if_valid_o && if_ready_i && instr_rvalid_i) found = 1'b1;
      else tick();
    end
    chk("hs_rv_found", 32'(found), 32'd1);
    n_hs = hs_log.size();
    redirect_to(32'h0000_0500);
    chk("rdhs_counted", 32'(hs_log.size()), 32'(n_hs + 1));
    chk("rdhs_empty", 32'(if_valid_o), 32'd0);
    ticks(8);

    // fetch PC wraps to zero
    gl_mark = grant_log.size();
    redirect_to(32'hFFFF_FFF8);
    ticks(10);
    idx = -1;
    for (int j = gl_mark; j < grant_log.size(); j++) begin
      v = grant_log[j];
      if (idx < 0 && v == 32'hFFFF_FFF8) idx = j;
    end
    chk("wrap_found", 32'(idx >= 0 && idx + 2 < grant_log.size()), 32'd1);
    if (idx >= 0 && idx + 2 < grant_log.size()) begin
      chk("wrap_fffc", grant_log[idx + 1], 32'hFFFF_FFFC);
      chk("wrap_zero", grant_log[idx + 2], 32'h0000_0000);
    end

    // asynchronous reset mid-stream
    #2;
    rst_i = 1'b1;
    #1;
    chk("mrst_req", 32'(instr_req_o), 32'd0);
    chk("mrst_addr", instr_addr_o, 32'h0000_0100);
    chk("mrst_valid", 32'(if_valid_o), 32'd0);
    chk("mrst_instr", if_instr_o, 32'h0);
    chk("mrst_pc", if_pc_o, 32'h0);
    model_reset();
    mem_q.delete();
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = 32'h0;
    ticks(2);
    rst_i = 1'b0;
    n_hs = hs_log.size();
    ticks(10);
    chk("post_rst_hs", 32'(hs_log.size() > n_hs), 32'd1);
    if (hs_log.size() > n_hs) chk("post_rst_pc", hs_log[n_hs], 32'h0000_0100);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
